alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU with valid/ready handshakes on both sides.
//                Single-cycle add/sub/logic/shift/compare operations and a
//                multi-cycle shift-and-add unsigned multiplier (low/high half).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [3:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam int               c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(WIDTH);
    localparam logic [WIDTH-1:0] c_WIDTH_B  = WIDTH[WIDTH-1:0];

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_NOR  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_SHL  = 4'h4;
    localparam logic [3:0] c_OP_SRA  = 4'h5;
    localparam logic [3:0] c_OP_SRL  = 4'h6;
    localparam logic [3:0] c_OP_SLT  = 4'h7;
    localparam logic [3:0] c_OP_MUL  = 4'h8;
    localparam logic [3:0] c_OP_MULH = 4'h9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Multiplier working registers
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic               r_is_mulh;

    // Registered result and flags
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;

    logic               w_fire;
    logic               w_is_mul_op;
    logic               w_mul_done;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHW-1:0]     w_shamt;
    logic               w_b_big;
    logic [WIDTH:0]     w_shl_ext;
    logic [WIDTH:0]     w_srl_ext;
    logic signed [WIDTH:0] w_sra_ext;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_mul_res;
    logic               w_mul_ovf;

    assign in_ready    = !Reset && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_fire      = in_valid && in_ready;
    assign w_is_mul_op = (OP == c_OP_MUL) || (OP == c_OP_MULH);
    assign w_mul_done  = (r_state == MUL) && (r_cnt == '0);

    // Extended shifts carry the last bit shifted out in the extra position;
    // a zero shift amount naturally leaves that position at 0.
    assign w_sum     = {1'b0, input_a} + {1'b0, input_b};
    assign w_diff    = input_a - input_b;
    assign w_shamt   = input_b[SHW-1:0];
    assign w_b_big   = (input_b >= c_WIDTH_B);
    assign w_shl_ext = {1'b0, input_a} << w_shamt;
    assign w_srl_ext = {input_a, 1'b0} >> w_shamt;
    assign w_sra_ext = $signed({input_a, 1'b0}) >>> w_shamt;

    assign w_mul_res = r_is_mulh ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    assign w_mul_ovf = !r_is_mulh && (r_acc[2*WIDTH-1:WIDTH] != '0);

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign carry     = r_carry;
    assign ovf       = r_ovf;

    // Single-cycle result and flags for the presented opcode
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (OP)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != input_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff;
                w_carry = (input_a >= input_b);
                w_ovf   = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != input_a[WIDTH-1]);
            end
            c_OP_NOR: w_res = ~(input_a | input_b);
            c_OP_AND: w_res = input_a & input_b;
            c_OP_SHL: begin
                if (!w_b_big) begin
                    w_res   = w_shl_ext[WIDTH-1:0];
                    w_carry = w_shl_ext[WIDTH];
                end
            end
            c_OP_SRA: begin
                if (w_b_big) begin
                    w_res   = {WIDTH{input_a[WIDTH-1]}};
                    w_carry = input_a[WIDTH-1];
                end else begin
                    w_res   = w_sra_ext[WIDTH:1];
                    w_carry = w_sra_ext[0];
                end
            end
            c_OP_SRL: begin
                if (!w_b_big) begin
                    w_res   = w_srl_ext[WIDTH:1];
                    w_carry = w_srl_ext[0];
                end
            end
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
            default:  w_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: multiply opcodes occupy MUL until the counter is spent
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fire && w_is_mul_op) w_state_nxt = MUL;
            MUL:     if (w_mul_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift-and-add multiplier: load on accept, one partial product per edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_is_mulh <= 1'b0;
        end else if (w_fire && w_is_mul_op) begin
            r_mcand   <= {{WIDTH{1'b0}}, input_a};
            r_mplier  <= input_b;
            r_acc     <= '0;
            r_cnt     <= c_CNT_INIT;
            r_is_mulh <= (OP == c_OP_MULH);
        end else if ((r_state == MUL) && (r_cnt != '0)) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // Output register: load on completion, hold under backpressure, clear on consume
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_fire && !w_is_mul_op) begin
            r_out       <= w_res;
            r_out_valid <= 1'b1;
            r_zero      <= (w_res == '0);
            r_neg       <= w_res[WIDTH-1];
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
        end else if (w_mul_done) begin
            r_out       <= w_mul_res;
            r_out_valid <= 1'b1;
            r_zero      <= (w_mul_res == '0);
            r_neg       <= w_mul_res[WIDTH-1];
            r_carry     <= 1'b0;
            r_ovf       <= w_mul_ovf;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
